lsu_mem_sequencer: RTL
======================

# lsu_mem_sequencer

Multi-cycle load/store sequencer between the core's MEM stage and a handshaked data-memory bus. It takes decoded memory-access controls:
- load/store width codes as produced by the control unit;
- effective address;
- store data.

It freezes the pipeline with `stall_o` while it drives one bus transaction. It returns sign- or zero-extended load data. Misaligned accesses and unanswered bus requests are detected and reported instead of being issued or hanging the core.

## Interface
- `TIMEOUT`, default 16: cycles in REQ without `bus_ack_i` before abort; 0 disables timeout.
- `clk` in 1: single clock, all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_i` in 1: MEM-stage instruction is a load (ResultSrc == 2'b01).
- `load_type_i` in 3: 000 lw, 001 lb, 010 lh, 011 lbu, 100 lhu; 101–111 treated as lw.
- `store_type_i` in 2: 00 none, 01 sb, 10 sh, 11 sw.
- `addr_i` in 32: effective byte address (ALU result).
- `wdata_i` in 32: store data (rs2).
- `stall_o` out 1: freeze IF/ID/EX/MEM registers.
- `rdata_o` out 32: extended load result, valid with `rdata_valid_o`.
- `rdata_valid_o` out 1: one-cycle pulse, load result ready.
- `misaligned_o` out 1: one-cycle pulse, access rejected.
- `timeout_o` out 1: one-cycle pulse, bus transaction aborted.
- `bus_req_o` out 1: request, held until ack or abort.
- `bus_we_o` out 1: 1 = write.
- `bus_addr_o` out 32: `{addr[31:2],2'b00}`.
- `bus_be_o` out 4: byte enables (writes); 4'b1111 for reads.
- `bus_wdata_o` out 32: lane-replicated store data.
- `bus_ack_i` in 1: completes request this cycle; `bus_rdata_i` valid with it.
- `bus_rdata_i` in 32: read word.

## Operation
- FSM states: IDLE, REQ, DONE. Reset → IDLE; all outputs 0; timeout counter 0; captured access registers 0.
- Access request in IDLE: `store_type_i != 0` or `load_i`. If both are set, the store wins and the load is ignored.
- Misaligned: lw with `addr[1:0] != 0`; lh/lhu/sh with `addr[0] != 0`. Misaligned request in IDLE:
  - `misaligned_o` = 1 next cycle;
  - no bus activity, no stall;
  - state stays IDLE;
  - `rdata_o` = 0.
- Aligned request in IDLE:
  - `stall_o` = 1 combinationally in the same cycle;
  - on the edge, capture type, `addr[1:0]`, bus address, BE and wdata;
  - → REQ.
- REQ:
  - `bus_req_o` = 1, `stall_o` = 1; all bus fields stable from registers;
  - counter increments each cycle;
  - `bus_ack_i` → DONE, capture extended read data;
  - counter reaching `TIMEOUT` (when nonzero) without ack → DONE with `timeout_o` pulse and `rdata_o` = 0.
- DONE:
  - `stall_o` = 0; the held instruction retires this cycle;
  - `rdata_valid_o` = 1 for loads only;
  - inputs ignored; → IDLE; counter cleared.
- Store lanes:
  - sb: BE = `4'b0001 << addr[1:0]`, wdata = `{4{wdata_i[7:0]}}`;
  - sh: BE = `addr[1] ? 4'b1100 : 4'b0011`, wdata = `{2{wdata_i[15:0]}}`;
  - sw: BE = 4'b1111, wdata = `wdata_i`.
- Load extract: lane = `bus_rdata_i >> (8*addr[1:0])`.
  - lb: sign-extend [7:0]; lbu: zero-extend [7:0].
  - lh: sign-extend [15:0]; lhu: zero-extend [15:0].
  - lw: full word.
- `bus_ack_i` outside REQ is ignored.
- `rst` in any state → IDLE next edge: `bus_req_o` drops, no pulses, and no completion is reported.

## Timing
- `stall_o` = `(IDLE & aligned_req) | REQ`, combinational from state and inputs; all other outputs are registered.
- Minimum access with ack in the first REQ cycle:
  - cycle 0: IDLE, stall;
  - cycle 1: REQ + ack, stall;
  - cycle 2: DONE, `rdata_valid_o`, no stall.
- This gives 2 stall cycles. Each additional wait cycle adds 1.
- Timeout: `timeout_o` asserts in the DONE cycle after the TIMEOUT-th REQ cycle, giving TIMEOUT+1 stall cycles in total.
- Back-to-back accesses: the next request is accepted in the IDLE cycle following DONE. There is no overlap.

## Test plan
- lb with `addr` = 0x103 and `bus_rdata_i` = 0x80FF_1234, ack after 2 wait cycles:
  - `bus_addr_o` = 0x100, BE = 4'b1111, `bus_we_o` = 0;
  - `rdata_o` = 0xFFFF_FF80;
  - 4 stall cycles; `rdata_valid_o` one cycle.
- lhu at 0x202 with `bus_rdata_i` = 0x9ABC_0000, immediate ack → `rdata_o` = 0x0000_9ABC, exactly 2 stall cycles.
- sb at 0x101 and sh at 0x102 with `wdata_i` = 0x1122_3344:
  - sb: BE = 0010, `bus_wdata_o` = 0x4444_4444;
  - sh: BE = 1100, `bus_wdata_o` = 0x3344_3344;
  - `rdata_valid_o` stays 0 in both.
- lw at 0x101 and sh at 0x003 → `misaligned_o` pulse, no `bus_req_o`, `stall_o` = 0 throughout.
- `TIMEOUT` = 4, no ack → `bus_req_o` high 4 cycles, `timeout_o` pulse, `rdata_o` = 0, `stall_o` released.
- `rst` asserted during REQ → next cycle `bus_req_o` = 0, `stall_o` = 0, state IDLE. A later `bus_ack_i` must produce no `rdata_valid_o`.

Source files
------------

// File: rtl/lsu_mem_sequencer_if.sv
// Handshaked data-memory bus between the load/store sequencer (master) and data memory (slave).
interface lsu_mem_sequencer_if;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  modport master (
    output bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    input  bus_ack_i, bus_rdata_i
  );

  modport slave (
    input  bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
    output bus_ack_i, bus_rdata_i
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// MEM-stage load/store sequencer: stalls the pipeline around one bus transaction,
// rejects misaligned accesses and aborts requests the bus never acknowledges.
module lsu_mem_sequencer #(
  parameter int TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_i,
  input  logic [2:0]                 load_type_i,
  input  logic [1:0]                 store_type_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  output logic                       stall_o,
  output logic [31:0]                rdata_o,
  output logic                       rdata_valid_o,
  output logic                       misaligned_o,
  output logic                       timeout_o,
  lsu_mem_sequencer_if.master        bus
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [2:0] LT_LB  = 3'b001;
  localparam logic [2:0] LT_LH  = 3'b010;
  localparam logic [2:0] LT_LBU = 3'b011;
  localparam logic [2:0] LT_LHU = 3'b100;
  localparam logic [1:0] ST_SB  = 2'b01;
  localparam logic [1:0] ST_SH  = 2'b10;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_DONE = 2'd2} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_we;
  logic [2:0]       r_load_type;
  logic [1:0]       r_off;
  logic [31:0]      r_bus_addr;
  logic [3:0]       r_be;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rdata;
  logic             r_rdata_valid;
  logic             r_misaligned;
  logic             r_timeout;

  logic             w_is_store;
  logic             w_access;
  logic             w_misaligned;
  logic             w_accept;
  logic             w_expired;
  logic             w_stall;
  logic             w_bus_req;
  logic [3:0]       w_be;
  logic [31:0]      w_wdata;
  logic [31:0]      w_lane;
  logic [31:0]      w_load_data;

  // A store always takes precedence over a simultaneous load.
  assign w_is_store = (store_type_i != 2'b00);
  assign w_access   = w_is_store | load_i;

  always_comb begin
    w_misaligned = 1'b0;
    if (w_is_store) begin
      w_misaligned = (store_type_i == ST_SH) & addr_i[0];
    end else if (load_i) begin
      case (load_type_i)
        LT_LB, LT_LBU: w_misaligned = 1'b0;
        LT_LH, LT_LHU: w_misaligned = addr_i[0];
        default:       w_misaligned = (addr_i[1:0] != 2'b00);
      endcase
    end
  end

  assign w_accept  = (r_state == S_IDLE) & w_access & ~w_misaligned;
  assign w_expired = (TIMEOUT != 0) && (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = wdata_i;
    case (store_type_i)
      ST_SB: begin
        w_be    = 4'b0001 << addr_i[1:0];
        w_wdata = {4{wdata_i[7:0]}};
      end
      ST_SH: begin
        w_be    = addr_i[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_lane = bus.bus_rdata_i >> {r_off, 3'b000};

  always_comb begin
    case (r_load_type)
      LT_LB:   w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      LT_LBU:  w_load_data = {24'h0, w_lane[7:0]};
      LT_LH:   w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      LT_LHU:  w_load_data = {16'h0, w_lane[15:0]};
      default: w_load_data = w_lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_REQ;
      S_REQ:   if (bus.bus_ack_i || w_expired) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_stall   = 1'b0;
    w_bus_req = 1'b0;
    case (r_state)
      S_IDLE:  w_stall = w_accept;
      S_REQ: begin
        w_stall   = 1'b1;
        w_bus_req = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt         <= '0;
      r_we          <= 1'b0;
      r_load_type   <= 3'b000;
      r_off         <= 2'b00;
      r_bus_addr    <= 32'h0;
      r_be          <= 4'b0000;
      r_wdata       <= 32'h0;
      r_rdata       <= 32'h0;
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_misaligned  <= 1'b0;
      r_timeout     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt   <= '0;
          r_rdata <= 32'h0;
          if (w_access && w_misaligned) r_misaligned <= 1'b1;
          if (w_accept) begin
            r_we        <= w_is_store;
            r_load_type <= load_type_i;
            r_off       <= addr_i[1:0];
            r_bus_addr  <= {addr_i[31:2], 2'b00};
            r_be        <= w_be;
            r_wdata     <= w_wdata;
          end
        end
        S_REQ: begin
          r_cnt <= r_cnt + 1'b1;
          if (bus.bus_ack_i) begin
            r_rdata       <= r_we ? 32'h0 : w_load_data;
            r_rdata_valid <= ~r_we;
          end else if (w_expired) begin
            r_timeout <= 1'b1;
            r_rdata   <= 32'h0;
          end
        end
        default: begin
          r_cnt   <= '0;
          r_rdata <= 32'h0;
        end
      endcase
    end
  end

  assign stall_o         = w_stall;
  assign rdata_o         = r_rdata;
  assign rdata_valid_o   = r_rdata_valid;
  assign misaligned_o    = r_misaligned;
  assign timeout_o       = r_timeout;
  assign bus.bus_req_o   = w_bus_req;
  assign bus.bus_we_o    = r_we;
  assign bus.bus_addr_o  = r_bus_addr;
  assign bus.bus_be_o    = r_be;
  assign bus.bus_wdata_o = r_wdata;
endmodule
